// File: rtl/pcs_stream_pkg.sv
// Shared types and helpers for the RX user stream checker.
// Beat geometry, FSM state encoding, byte-count decode.
package pcs_stream_pkg;

  localparam int DATA_W = 32;
  localparam int BYTES  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IN_FRAME,
    S_DROP
  } state_t;

  // Bytes carried by one beat: full on non-last beats.
  function automatic logic [2:0] vldb2bytes(
    input logic       last,
    input logic [1:0] vldb
  );
    return last ? ({1'b0, vldb} + 3'd1) : 3'd4;
  endfunction

endpackage

// File: rtl/sat_acc.sv
// Saturating accumulator used for the statistics counters.
// Sticks at all-ones instead of wrapping.
module sat_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] inc,
  output logic [W-1:0] q
);

  logic [W:0] sum;

  assign sum = {1'b0, q} + {1'b0, inc};

  // Clear has priority; carry out means saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/rx_stream_checker.sv
// Checks RX frames against an incrementing-byte pattern,
// measures length and keeps saturating statistics.
module rx_stream_checker
  import pcs_stream_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic [1:0]        rx_vldb_i,
  input  logic              rx_valid_i,
  input  logic              rx_last_i,
  input  logic              rx_user_i,
  output logic              res_valid_o,
  output logic [15:0]       res_len_o,
  output logic              res_ok_o,
  output logic [CNT_W-1:0]  frame_cnt_o,
  output logic [CNT_W-1:0]  byte_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              pat_err_o,
  output logic              len_err_o
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  state_t      state, state_nxt;
  logic [7:0]  exp_q;
  logic [15:0] len_q;
  logic        pat_q;

  logic [2:0]  nbytes;
  logic [7:0]  base;
  logic        beat_err;
  logic [16:0] len_sum;
  logic [15:0] len_add;
  logic        pat_add;
  logic        fin;
  logic        giant;
  logic        runt;
  logic        ok;
  logic [CNT_W-1:0] byte_inc;

  // Per-beat pattern compare and running length/error merge.
  always_comb begin
    nbytes   = vldb2bytes(rx_last_i, rx_vldb_i);
    base     = (state == S_IDLE) ? rx_data_i[7:0] : exp_q;
    beat_err = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if (3'(i) < nbytes &&
          rx_data_i[8*i +: 8] != base + 8'(i)) begin
        beat_err = 1'b1;
      end
    end
    len_sum = (state == S_IDLE) ? 17'd0 : {1'b0, len_q};
    len_sum = len_sum + {14'd0, nbytes};
    len_add = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    pat_add = ((state != S_IDLE) & pat_q) |
              ((state != S_DROP) & beat_err);
    fin     = rx_valid_i & rx_last_i;
    giant   = len_add > MAX_L;
    runt    = len_add < MIN_L;
    ok      = !(pat_add | runt | giant | rx_user_i);
  end

  // Next-state: last beat always returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (rx_valid_i) begin
      unique case (state)
        S_IDLE, S_IN_FRAME: begin
          if (rx_last_i)  state_nxt = S_IDLE;
          else if (giant) state_nxt = S_DROP;
          else            state_nxt = S_IN_FRAME;
        end
        S_DROP: begin
          if (rx_last_i) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM state register; clear also abandons a frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
    end else if (clear_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Running expectation, length and error of the open frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      exp_q <= '0;
      len_q <= '0;
      pat_q <= 1'b0;
    end else if (clear_i) begin
      exp_q <= '0;
      len_q <= '0;
      pat_q <= 1'b0;
    end else if (rx_valid_i) begin
      exp_q <= base + 8'd4;
      len_q <= len_add;
      pat_q <= pat_add;
    end
  end

  // Result register and sticky flags; clear beats a result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_valid_o <= 1'b0;
      res_len_o   <= '0;
      res_ok_o    <= 1'b0;
      pat_err_o   <= 1'b0;
      len_err_o   <= 1'b0;
    end else if (clear_i) begin
      res_valid_o <= 1'b0;
      res_len_o   <= '0;
      res_ok_o    <= 1'b0;
      pat_err_o   <= 1'b0;
      len_err_o   <= 1'b0;
    end else begin
      res_valid_o <= fin;
      if (fin) begin
        res_len_o <= len_add;
        res_ok_o  <= ok;
        if (pat_add)        pat_err_o <= 1'b1;
        if (runt || giant)  len_err_o <= 1'b1;
      end
    end
  end

  if (CNT_W > 16) begin : g_wide
    assign byte_inc = {{(CNT_W-16){1'b0}}, len_add};
  end else begin : g_narrow
    localparam logic [15:0] CMAX = 16'((1 << CNT_W) - 1);
    assign byte_inc = (len_add > CMAX) ? '1 : len_add[CNT_W-1:0];
  end

  sat_acc #(.W(CNT_W)) u_frame_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (clear_i),
    .en    (fin),
    .inc   (CNT_W'(1)),
    .q     (frame_cnt_o)
  );

  sat_acc #(.W(CNT_W)) u_byte_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (clear_i),
    .en    (fin),
    .inc   (byte_inc),
    .q     (byte_cnt_o)
  );

  sat_acc #(.W(CNT_W)) u_err_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (clear_i),
    .en    (fin & ~ok),
    .inc   (CNT_W'(1)),
    .q     (err_cnt_o)
  );

endmodule

// File: tb/tb_rx_stream_checker.sv
// Self-checking bench for rx_stream_checker.
// Directed table, corner sequences, randomized frames.
module tb_rx_stream_checker;

  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1518;
  localparam longint SMAX = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] rx_data = '0;
  logic [1:0]  rx_vldb = '0;
  logic        rx_valid = 1'b0;
  logic        rx_last = 1'b0;
  logic        rx_user = 1'b0;

  logic        res_valid, res_ok, pat_err, len_err;
  logic [15:0] res_len;
  logic [31:0] frame_cnt, byte_cnt, err_cnt;

  logic        res_valid_s, res_ok_s, pat_err_s, len_err_s;
  logic [15:0] res_len_s;
  logic [3:0]  frame_cnt_s, byte_cnt_s, err_cnt_s;

  int tests = 0;
  int fails = 0;

  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  longint m_frames, m_bytes, m_errs;
  bit m_pat, m_lerr;

  always #5 clk = ~clk;

  rx_stream_checker #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
    .rx_data_i(rx_data), .rx_vldb_i(rx_vldb),
    .rx_valid_i(rx_valid), .rx_last_i(rx_last),
    .rx_user_i(rx_user),
    .res_valid_o(res_valid), .res_len_o(res_len),
    .res_ok_o(res_ok), .frame_cnt_o(frame_cnt),
    .byte_cnt_o(byte_cnt), .err_cnt_o(err_cnt),
    .pat_err_o(pat_err), .len_err_o(len_err)
  );

  // Narrow-counter instance exposes saturation quickly.
  rx_stream_checker #(.CNT_W(4)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
    .rx_data_i(rx_data), .rx_vldb_i(rx_vldb),
    .rx_valid_i(rx_valid), .rx_last_i(rx_last),
    .rx_user_i(rx_user),
    .res_valid_o(res_valid_s), .res_len_o(res_len_s),
    .res_ok_o(res_ok_s), .frame_cnt_o(frame_cnt_s),
    .byte_cnt_o(byte_cnt_s), .err_cnt_o(err_cnt_s),
    .pat_err_o(pat_err_s), .len_err_o(len_err_s)
  );

  always @(negedge clk) begin
    if (res_valid) got_q.push_back({res_len, res_ok});
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic longint smin(input longint v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  // Reference: a byte is checked only if its beat starts
  // at or before MAX_LEN bytes into the frame.
  function automatic bit model_pat(input int len, input int ci);
    if (ci < 1 || ci >= len) return 1'b0;
    return (4 * (ci / 4)) <= MAX_LEN;
  endfunction

  task automatic model_reset();
    m_frames = 0; m_bytes = 0; m_errs = 0;
    m_pat = 0; m_lerr = 0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic expect_frame(input int len, input int ci, input bit user);
    bit pat, lerr, ok;
    pat  = model_pat(len, ci);
    lerr = (len < MIN_LEN) || (len > MAX_LEN);
    ok   = !(pat || lerr || user);
    exp_q.push_back({16'(len), ok});
    m_frames++; m_bytes += len;
    if (!ok) m_errs++;
    m_pat  = m_pat | pat;
    m_lerr = m_lerr | lerr;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0; rx_last = 1'b0; rx_data = $urandom;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int len, input logic [7:0] seed,
                            input int ci, input logic user,
                            input int gap_pct);
    int nb;
    nb = (len + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      logic [31:0] d;
      logic [7:0]  v;
      int left;
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        @(negedge clk);
        rx_valid = 1'b0; rx_last = 1'($urandom);
        rx_data = $urandom;
      end
      left = len - 4 * b;
      d = $urandom;
      for (int k = 0; k < 4; k++) begin
        if (k < left) begin
          v = seed + 8'(4 * b + k);
          if (4 * b + k == ci) v = v ^ 8'h01;
          d[8*k +: 8] = v;
        end
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = d;
      rx_last  = (b == nb - 1);
      rx_vldb  = (b == nb - 1) ? 2'(left - 1) : 2'($urandom);
      rx_user  = (b == nb - 1) ? user : 1'($urandom);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    rx_valid = 1'b0; rx_last = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  task automatic chk_results(input string nm);
    logic [16:0] g, e;
    repeat (3) @(negedge clk);
    chk({nm, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({nm, "_len"}, g[16:1], e[16:1]);
      chk({nm, "_ok"}, g[0], e[0]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, "_frame_cnt"}, frame_cnt, m_frames);
    chk({nm, "_byte_cnt"}, byte_cnt, m_bytes);
    chk({nm, "_err_cnt"}, err_cnt, m_errs);
    chk({nm, "_pat_err"}, pat_err, m_pat);
    chk({nm, "_len_err"}, len_err, m_lerr);
    chk({nm, "_frame_cnt_s"}, frame_cnt_s, smin(m_frames));
    chk({nm, "_byte_cnt_s"}, byte_cnt_s, smin(m_bytes));
    chk({nm, "_err_cnt_s"}, err_cnt_s, smin(m_errs));
  endtask

  typedef struct {
    int len; int seed; int ci; bit user;
    int exp_len; bit exp_ok; bit exp_pat; bit exp_lerr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [16:0] g;
    tbl.push_back('{60,   8'h84, -1, 0, 60,   1, 0, 0});
    tbl.push_back('{61,   8'h00, -1, 0, 61,   1, 0, 0});
    tbl.push_back('{60,   8'h10, 17, 0, 60,   0, 1, 0});
    tbl.push_back('{64,   8'h22, -1, 1, 64,   0, 0, 0});
    tbl.push_back('{59,   8'h33, -1, 0, 59,   0, 0, 1});
    tbl.push_back('{1519, 8'h44, -1, 0, 1519, 0, 0, 1});
    tbl.push_back('{1518, 8'hFE, -1, 0, 1518, 1, 0, 0});
    tbl.push_back('{1,    8'h55, -1, 0, 1,    0, 0, 1});
    tbl.push_back('{3,    8'h66, -1, 0, 3,    0, 0, 1});
    tbl.push_back('{63,   8'hFF, 62, 0, 63,   0, 1, 0});

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_res_len", res_len, 0);
    chk("rst_res_ok", res_ok, 0);
    chk_cnt("reset");

    // Directed table
    for (int t = 0; t < tbl.size(); t++) begin
      do_clear();
      send_frame(tbl[t].len, 8'(tbl[t].seed), tbl[t].ci,
                 tbl[t].user, 0);
      idle(3);
      chk($sformatf("tbl%0d_count", t), got_q.size(), 1);
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        chk($sformatf("tbl%0d_len", t), g[16:1], tbl[t].exp_len);
        chk($sformatf("tbl%0d_ok", t), g[0], tbl[t].exp_ok);
      end
      chk($sformatf("tbl%0d_pat_err", t), pat_err, tbl[t].exp_pat);
      chk($sformatf("tbl%0d_len_err", t), len_err, tbl[t].exp_lerr);
      chk($sformatf("tbl%0d_frame_cnt", t), frame_cnt, 1);
      chk($sformatf("tbl%0d_byte_cnt", t), byte_cnt, tbl[t].exp_len);
      chk($sformatf("tbl%0d_err_cnt", t), err_cnt, !tbl[t].exp_ok);
    end

    // Back-to-back 61 then 62
    do_clear();
    send_frame(61, 8'h07, -1, 0, 0); expect_frame(61, -1, 0);
    send_frame(62, 8'h91, -1, 0, 0); expect_frame(62, -1, 0);
    idle(1);
    chk_results("b2b");
    chk("b2b_byte_cnt_abs", byte_cnt, 123);
    chk_cnt("b2b");

    // Corrupt then good frame: sticky flag remains
    do_clear();
    send_frame(60, 8'hA0, 17, 0, 0); expect_frame(60, 17, 0);
    send_frame(60, 8'hB0, -1, 0, 30); expect_frame(60, -1, 0);
    idle(1);
    chk_results("corrupt_good");
    chk("corrupt_err_cnt_abs", err_cnt, 1);
    chk_cnt("corrupt_good");

    // Runt then giant
    do_clear();
    send_frame(59, 8'h01, -1, 0, 0); expect_frame(59, -1, 0);
    idle(2);
    send_frame(1519, 8'h02, -1, 0, 0); expect_frame(1519, -1, 0);
    idle(1);
    chk_results("runt_giant");
    chk("runt_giant_err_abs", err_cnt, 2);
    chk_cnt("runt_giant");

    // Clear coincident with a last beat drops the result
    do_clear();
    send_frame(60, 8'h3C, -1, 0, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; rx_valid = 1'b0; rx_last = 1'b0;
    idle(3);
    chk("clear_win_pulses", got_q.size(), 0);
    chk_cnt("clear_win");

    // Reset mid-frame after 8 beats
    do_clear();
    send_frame(60, 8'h11, -1, 0, 0); expect_frame(60, -1, 0);
    idle(2);
    chk_results("pre_rst");
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      rx_valid = 1'b1; rx_last = 1'b0;
      rx_data = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
    end
    @(negedge clk);
    rx_valid = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    chk("midrst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    send_frame(60, 8'hC4, -1, 0, 0); expect_frame(60, -1, 0);
    idle(1);
    chk_results("midrst");
    chk("midrst_frame_abs", frame_cnt, 1);
    chk_cnt("midrst");

    // Randomized frames vs reference model
    do_clear();
    for (int f = 0; f < 40; f++) begin
      int len, ci;
      bit user;
      len  = ($urandom_range(0, 9) == 0) ? $urandom_range(1500, 1530)
                                         : $urandom_range(1, 130);
      ci   = ($urandom_range(0, 3) == 0 && len > 1)
             ? $urandom_range(1, len - 1) : -1;
      user = ($urandom_range(0, 9) == 0);
      send_frame(len, 8'($urandom), ci, user,
                 $urandom_range(0, 1) * 25);
      expect_frame(len, ci, user);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);
    chk_results("rand");
    chk_cnt("rand");
    chk("sat_frame_cnt_s", frame_cnt_s, 4'hF);

    do_clear();
    chk_cnt("final_clear");
    chk("final_clear_s", frame_cnt_s, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
